// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one registered memory_controller port between
// NUM_REQ requester engines. Each access is IDLE/RESP -> ACCESS -> RESP. Read
// data and a one-hot rvalid appear in the cycle after RESP.
//
// Handshake: a requester raises req[i] with its we/lock/addr/wdata slice and
// holds it until it sees gnt[i]. gnt[i] is a one-cycle pulse meaning the
// request was accepted and is on the memory port. On the edge after gnt[i],
// the requester either drops req[i] or presents its next request. The arbiter
// ignores the served requester's req during the RESP of that same access.
// rvalid[i] is a one-cycle pulse with rdata, and is returned for writes too.
module mem_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          busy,
  output logic [ADDR_WIDTH-1:0]         memory_controller_address,
  output logic                          memory_controller_write_enable,
  output logic [DATA_WIDTH-1:0]         memory_controller_in,
  input  logic [DATA_WIDTH-1:0]         memory_controller_out,
  output logic [1:0]                    state_dbg
);

  localparam int IW = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_next;

  logic [IW-1:0]      rr_ptr;      // last winner; the scan starts just above it
  logic [IW-1:0]      cur;         // requester owning the access in flight
  logic               lat_lock;    // lock bit latched with the current access
  logic               lock_valid;
  logic [IW-1:0]      lock_owner;

  logic [NUM_REQ-1:0] elig;
  logic [IW-1:0]      win;
  logic [IW-1:0]      scan_idx;
  logic               win_found;
  logic               arb;

  logic [NUM_REQ-1:0]    gnt_n, rvalid_n;
  logic [DATA_WIDTH-1:0] rdata_n, mc_in_n;
  logic [ADDR_WIDTH-1:0] mc_addr_n;
  logic                  mc_we_n, busy_n;

  assign state_dbg = state;

  // Eligibility (lock and served-requester masks), then a round-robin scan.
  always_comb begin
    elig = req;
    if (lock_valid) elig = elig & (ONE << lock_owner);
    if (state == RESP) elig = elig & ~(ONE << cur);
    win       = '0;
    win_found = 1'b0;
    scan_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!win_found && elig[scan_idx]) begin
        win       = scan_idx;
        win_found = 1'b1;
      end
    end
    arb = win_found && (state != ACCESS);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = win_found ? ACCESS : IDLE;
      ACCESS:  state_next = RESP;
      RESP:    state_next = win_found ? ACCESS : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    gnt_n     = '0;
    rvalid_n  = '0;
    rdata_n   = rdata;
    mc_we_n   = 1'b0;
    mc_addr_n = memory_controller_address;
    mc_in_n   = memory_controller_in;
    busy_n    = (state_next != IDLE);
    if (arb) begin
      gnt_n     = ONE << win;
      mc_we_n   = req_we[win];
      mc_addr_n = req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
      mc_in_n   = req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
    end
    if (state == RESP) begin
      rvalid_n = ONE << cur;
      rdata_n  = memory_controller_out;
    end
  end

  // Output registers; the address/data registers double as the access latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt                            <= '0;
      rvalid                         <= '0;
      rdata                          <= '0;
      busy                           <= 1'b0;
      memory_controller_write_enable <= 1'b0;
      memory_controller_address      <= '0;
      memory_controller_in           <= '0;
    end else begin
      gnt                            <= gnt_n;
      rvalid                         <= rvalid_n;
      rdata                          <= rdata_n;
      busy                           <= busy_n;
      memory_controller_write_enable <= mc_we_n;
      memory_controller_address      <= mc_addr_n;
      memory_controller_in           <= mc_in_n;
    end
  end

  // Round-robin pointer, in-flight owner and burst lock bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr     <= IW'(NUM_REQ - 1);
      cur        <= '0;
      lat_lock   <= 1'b0;
      lock_valid <= 1'b0;
      lock_owner <= '0;
    end else begin
      if (arb) begin
        rr_ptr   <= win;
        cur      <= win;
        lat_lock <= req_lock[win];
      end
      if (state == ACCESS) begin
        lock_valid <= lat_lock;
        lock_owner <= cur;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a cycle table for single/write/read accesses,
// an idle check, lock-burst and contention traffic, and reset during ACCESS.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, req_we, req_lock;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  gnt, rvalid;
  logic [31:0] rdata;
  logic        busy;
  logic [31:0] mc_addr, mc_in, mc_out;
  logic        mc_we;
  logic [1:0]  state_dbg;

  int n_vec = 0;
  int n_bad = 0;

  logic [33:0] exp_q[$];
  int          got_order[$];
  int          exp_order[$];
  int          gnt_cyc[$];

  // Clock.
  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_we(req_we),
    .req_lock(req_lock),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .gnt(gnt),
    .rvalid(rvalid),
    .rdata(rdata),
    .busy(busy),
    .memory_controller_address(mc_addr),
    .memory_controller_write_enable(mc_we),
    .memory_controller_in(mc_in),
    .memory_controller_out(mc_out),
    .state_dbg(state_dbg)
  );

  // Memory model: 1-cycle read latency, new data on read-during-write.
  logic [31:0] mem [16] = '{32'h100, 32'h101, 32'h102, 32'h103,
                            32'h104, 32'hA5,  32'h106, 32'h107,
                            32'h108, 32'h109, 32'h10A, 32'h10B,
                            32'h10C, 32'h10D, 32'h10E, 32'h10F};
  always @(posedge clk) begin
    if (mc_we) mem[mc_addr[3:0]] <= mc_in;
    mc_out <= mc_we ? mc_in : mem[mc_addr[3:0]];
  end

  typedef struct {
    logic [1:0]  e_gnt;
    logic [1:0]  e_rv;
    logic [31:0] e_rdata;
    logic        e_busy;
    logic        e_we;
    logic [31:0] e_addr;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] d1;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mkv(logic [1:0] e_gnt, logic [1:0] e_rv, logic [31:0] e_rdata,
                               logic e_busy, logic e_we, logic [31:0] e_addr,
                               logic [1:0] r, logic [1:0] w, logic [31:0] a0,
                               logic [31:0] a1, logic [31:0] d1);
    vec_t v;
    v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_rdata = e_rdata; v.e_busy = e_busy;
    v.e_we = e_we; v.e_addr = e_addr; v.req = r; v.we = w; v.a0 = a0;
    v.a1 = a1; v.d1 = d1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Traffic driver: requester i issues acc_i reads to 8+4*i+k; requester 1
  // locks its first lock1_n accesses. Grants and read data are scoreboarded.
  task automatic run_traffic(input int acc0, input int acc1, input int lock1_n, input int budget);
    int acc[2];
    int iss[2];
    int cyc;
    int g;
    logic [33:0] e;
    acc[0] = acc0; acc[1] = acc1;
    iss[0] = 0; iss[1] = 0;
    cyc = 0;
    got_order.delete();
    gnt_cyc.delete();
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      req[i]      = (iss[i] < acc[i]);
      req_we[i]   = 1'b0;
      req_lock[i] = (i == 1) && (iss[1] < lock1_n);
      req_addr[i*32 +: 32] = 32'(8 + 4*i + iss[i]);
    end
    while (!(iss[0] == acc[0] && iss[1] == acc[1] && exp_q.size() == 0) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (rvalid != 2'b00) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL rvalid_unexpected: got rvalid=%b with nothing outstanding", rvalid);
        end else begin
          e = exp_q.pop_front();
          chk("rvalid_data", {rvalid, rdata}, {2'b01 << e[33:32], e[31:0]});
        end
      end
      if (gnt != 2'b00) begin
        g = gnt[1] ? 1 : 0;
        chk("gnt_onehot", $countones(gnt), 1);
        chk("gnt_addr", {mc_we, mc_addr}, {1'b0, 32'(8 + 4*g + iss[g])});
        got_order.push_back(g);
        gnt_cyc.push_back(cyc);
        exp_q.push_back({2'(g), 32'h100 + 32'(8 + 4*g + iss[g])});
        iss[g]++;
      end
      for (int i = 0; i < 2; i++) begin
        req[i]      = (iss[i] < acc[i]);
        req_lock[i] = (i == 1) && (iss[1] < lock1_n);
        req_addr[i*32 +: 32] = 32'(8 + 4*i + iss[i]);
      end
    end
    if (!(iss[0] == acc[0] && iss[1] == acc[1] && exp_q.size() == 0)) begin
      n_vec++; n_bad++;
      $display("FAIL traffic_timeout: got iss0=%0d iss1=%0d pending=%0d, expected all done",
               iss[0], iss[1], exp_q.size());
    end
    req = '0; req_lock = '0;
  endtask

  task automatic check_order(input string name);
    chk({name, "_len"}, got_order.size(), exp_order.size());
    for (int j = 0; j < exp_order.size(); j++) begin
      if (j < got_order.size()) chk(name, got_order[j], exp_order[j]);
    end
  endtask

  initial begin
    reset = 1'b0; req = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", {gnt, rvalid, rdata, busy, mc_we, mc_addr, mc_in, state_dbg}, '0);
    reset = 1'b1;

    // Cycle table: single read of addr 5, write 3C to addr 3 by req 1, read back by req 0.
    tbl[0]  = mkv(2'b00, 2'b00, 32'h0,  1'b0, 1'b0, 32'd0, 2'b01, 2'b00, 32'd5, 32'd0, 32'h0);
    tbl[1]  = mkv(2'b01, 2'b00, 32'h0,  1'b1, 1'b0, 32'd5, 2'b00, 2'b00, 32'd0, 32'd0, 32'h0);
    tbl[2]  = mkv(2'b00, 2'b00, 32'h0,  1'b1, 1'b0, 32'd5, 2'b00, 2'b00, 32'd0, 32'd0, 32'h0);
    tbl[3]  = mkv(2'b00, 2'b01, 32'hA5, 1'b0, 1'b0, 32'd5, 2'b10, 2'b10, 32'd0, 32'd3, 32'h3C);
    tbl[4]  = mkv(2'b10, 2'b00, 32'hA5, 1'b1, 1'b1, 32'd3, 2'b00, 2'b00, 32'd0, 32'd0, 32'h0);
    tbl[5]  = mkv(2'b00, 2'b00, 32'hA5, 1'b1, 1'b0, 32'd3, 2'b00, 2'b00, 32'd0, 32'd0, 32'h0);
    tbl[6]  = mkv(2'b00, 2'b10, 32'h3C, 1'b0, 1'b0, 32'd3, 2'b01, 2'b00, 32'd3, 32'd0, 32'h0);
    tbl[7]  = mkv(2'b01, 2'b00, 32'h3C, 1'b1, 1'b0, 32'd3, 2'b00, 2'b00, 32'd0, 32'd0, 32'h0);
    tbl[8]  = mkv(2'b00, 2'b00, 32'h3C, 1'b1, 1'b0, 32'd3, 2'b00, 2'b00, 32'd0, 32'd0, 32'h0);
    tbl[9]  = mkv(2'b00, 2'b01, 32'h3C, 1'b0, 1'b0, 32'd3, 2'b00, 2'b00, 32'd0, 32'd0, 32'h0);
    tbl[10] = mkv(2'b00, 2'b00, 32'h3C, 1'b0, 1'b0, 32'd3, 2'b00, 2'b00, 32'd0, 32'd0, 32'h0);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk($sformatf("table_%0d", i), {gnt, rvalid, rdata, busy, mc_we, mc_addr},
          {tbl[i].e_gnt, tbl[i].e_rv, tbl[i].e_rdata, tbl[i].e_busy, tbl[i].e_we, tbl[i].e_addr});
      req       = tbl[i].req;
      req_we    = tbl[i].we;
      req_addr  = {tbl[i].a1, tbl[i].a0};
      req_wdata = {tbl[i].d1, 32'h0};
    end

    // Idle: nothing requested for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle", {gnt, rvalid, mc_we, busy}, '0);
    end

    // Lock burst by requester 1 while requester 0 waits.
    exp_order = '{1, 1, 1, 0};
    run_traffic(1, 3, 2, 200);
    check_order("lock_order");

    // Reset asserted during the ACCESS of a write to addr 7.
    @(negedge clk);
    req = 2'b01; req_we = 2'b01; req_addr = {32'd0, 32'd7}; req_wdata = {32'h0, 32'h77};
    @(negedge clk);
    chk("rst_access", {gnt, mc_we, mc_addr}, {2'b01, 1'b1, 32'd7});
    req = '0; req_we = '0;
    #2 reset = 1'b0;
    #1 chk("rst_async", {gnt, rvalid, mc_we, busy, mc_addr, state_dbg}, '0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_rvalid", {rvalid, busy, state_dbg}, '0);
    end

    // Contention: both requesters continuously; first grant shows reset priority.
    exp_order = '{0, 1, 0, 1, 0, 1};
    run_traffic(3, 3, 0, 200);
    check_order("rr_order");
    for (int j = 1; j < gnt_cyc.size(); j++) chk("gnt_spacing", gnt_cyc[j] - gnt_cyc[j-1], 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
